branch_predictor: RTL and testbench

- Parametrised dynamic branch/jump predictor for the 5-stage RV32 pipeline; successor to the static "backward taken" decode-stage predictor.
- Decode side: combinational lookup on the fetched PC gives conditional-branch direction, plus a JALR target from a small BTB.
- Execute side: registered update from resolved outcomes.
- Adds bimodal and gshare modes, JALR target prediction, and misprediction counters.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_btb.sv | 58 +++++
 rtl/branch_predictor.sv | 129 ++++++++++++
 tb/tb_branch_predictor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor and the decode stage.
package branch_predictor_pkg;

    // Predictor mode encodings
    localparam int unsigned BP_STATIC  = 0;
    localparam int unsigned BP_BIMODAL = 1;
    localparam int unsigned BP_GSHARE  = 2;

    // Weakly not-taken reset value of a saturating counter of the given width.
    function automatic logic [31:0] ctr_reset(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // Word index field pc[idx_bits+1:2], right-aligned.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag field pc[idx_bits+tag_bits+1:idx_bits+2], right-aligned.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_bits,
                                           input int unsigned tag_bits);
        return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped, tagged JALR target store with per-entry valid bits.
module bp_btb
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_BITS = 3,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lk_pc,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    output logic            hit_c,
    output logic [XLEN-1:0] target_c
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [XLEN-1:0]     tgt_q [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;
    logic                unused_c;

    assign lk_idx   = IDX_BITS'(pc_index(32'(lk_pc), IDX_BITS));
    assign lk_tag   = TAG_BITS'(pc_tag(32'(lk_pc), IDX_BITS, TAG_BITS));
    assign wr_idx   = IDX_BITS'(pc_index(32'(wr_pc), IDX_BITS));
    assign wr_tag   = TAG_BITS'(pc_tag(32'(wr_pc), IDX_BITS, TAG_BITS));
    // Target bit 0 is always stored as zero
    assign unused_c = wr_target[0];

    // Valid bits: cleared by reset, set on every write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and target payload; meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= {wr_target[XLEN-1:1], 1'b0};
        end
    end

    assign hit_c    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign target_c = hit_c ? tgt_q[lk_idx] : '0;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic conditional-branch direction predictor (static/bimodal/gshare) with JALR BTB and stats.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MODE         = 2,
    parameter int unsigned IDX_BITS     = 6,
    parameter int unsigned CTR_BITS     = 2,
    parameter int unsigned GHR_BITS     = 6,
    parameter int unsigned BTB_IDX_BITS = 3,
    parameter int unsigned BTB_TAG_BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lk_pc,
    input  logic            lk_bneg,
    output logic            pred_taken,
    output logic            pred_jalr_hit,
    output logic [XLEN-1:0] pred_jalr_target,
    input  logic            up_valid,
    input  logic [XLEN-1:0] up_pc,
    input  logic            up_is_branch,
    input  logic            up_is_jalr,
    input  logic            up_taken,
    input  logic [XLEN-1:0] up_target,
    input  logic            up_mispredict,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned PHT_ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic br_upd;
    logic unused_c;

    assign br_upd   = up_valid && up_is_branch;
    // Inputs that only some modes consume
    assign unused_c = ^{lk_bneg, up_taken, up_is_branch};

    generate
        if (MODE == BP_STATIC) begin : g_static
            // Backward-taken / forward-not-taken from the immediate sign
            assign pred_taken = lk_bneg;
        end else begin : g_dynamic
            logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
            logic [IDX_BITS-1:0] hist_c;
            logic [IDX_BITS-1:0] lk_idx;
            logic [IDX_BITS-1:0] up_idx;

            if (MODE == BP_GSHARE) begin : g_ghr
                logic [GHR_BITS-1:0] ghr_q;

                // Global history, shifted only on resolved branches
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        ghr_q <= '0;
                    end else if (br_upd) begin
                        ghr_q <= GHR_BITS'({ghr_q, up_taken});
                    end
                end

                assign hist_c = IDX_BITS'(ghr_q);
            end else begin : g_no_ghr
                assign hist_c = '0;
            end

            assign lk_idx = IDX_BITS'(pc_index(32'(lk_pc), IDX_BITS)) ^ hist_c;
            assign up_idx = IDX_BITS'(pc_index(32'(up_pc), IDX_BITS)) ^ hist_c;

            // Saturating counter training on resolved branches
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PHT_ENTRIES; i++) begin
                        pht_q[i] <= CTR_RST;
                    end
                end else if (br_upd) begin
                    if (up_taken) begin
                        if (pht_q[up_idx] != CTR_MAX) begin
                            pht_q[up_idx] <= pht_q[up_idx] + CTR_BITS'(1);
                        end
                    end else begin
                        if (pht_q[up_idx] != '0) begin
                            pht_q[up_idx] <= pht_q[up_idx] - CTR_BITS'(1);
                        end
                    end
                end
            end

            assign pred_taken = pht_q[lk_idx][CTR_BITS-1];
        end
    endgenerate

    bp_btb #(
        .XLEN     (XLEN),
        .IDX_BITS (BTB_IDX_BITS),
        .TAG_BITS (BTB_TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lk_pc     (lk_pc),
        .wr_en     (up_valid && up_is_jalr),
        .wr_pc     (up_pc),
        .wr_target (up_target),
        .hit_c     (pred_jalr_hit),
        .target_c  (pred_jalr_target)
    );

    // Resolution and misprediction counters, free-running modulo 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (up_valid && (up_is_branch || up_is_jalr)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (up_valid && up_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

    // A resolution cannot be both a B-type and a JALR
    assert property (@(posedge clk) disable iff (reset)
        !(up_valid && up_is_branch && up_is_jalr));

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal and gshare instances share stimulus.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] lk_pc;
    logic        lk_bneg;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_is_branch;
    logic        up_is_jalr;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_mispredict;

    logic        b_pt, b_hit, g_pt, g_hit;
    logic [31:0] b_tgt, g_tgt, b_br, b_mis, g_br, g_mis;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor #(.MODE(1)) u_bim (
        .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_bneg(lk_bneg),
        .pred_taken(b_pt), .pred_jalr_hit(b_hit), .pred_jalr_target(b_tgt),
        .up_valid(up_valid), .up_pc(up_pc), .up_is_branch(up_is_branch),
        .up_is_jalr(up_is_jalr), .up_taken(up_taken), .up_target(up_target),
        .up_mispredict(up_mispredict), .stat_branches(b_br), .stat_mispredicts(b_mis)
    );

    branch_predictor #(.MODE(2)) u_gsh (
        .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_bneg(lk_bneg),
        .pred_taken(g_pt), .pred_jalr_hit(g_hit), .pred_jalr_target(g_tgt),
        .up_valid(up_valid), .up_pc(up_pc), .up_is_branch(up_is_branch),
        .up_is_jalr(up_is_jalr), .up_taken(up_taken), .up_target(up_target),
        .up_mispredict(up_mispredict), .stat_branches(g_br), .stat_mispredicts(g_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lk;
        logic        uv;
        logic [31:0] upc;
        logic        ub;
        logic        uj;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        e_pt;
        logic        e_hit;
        logic [31:0] e_tgt;
        logic [31:0] e_br;
        logic [31:0] e_mis;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                         input logic ub, input logic uj, input logic ut,
                         input logic [31:0] utgt, input logic um);
        lk_pc         = lk;
        up_valid      = uv;
        up_pc         = upc;
        up_is_branch  = ub;
        up_is_jalr    = uj;
        up_taken      = ut;
        up_target     = utgt;
        up_mispredict = um;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // lk, uv, upc, ub, uj, ut, utgt, um | pt, hit, tgt, br, mis
        tbl[0]  = '{32'h100, 0, 32'h000, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0};
        tbl[1]  = '{32'h100, 1, 32'h100, 1, 0, 1, 32'h0,    1, 0, 0, 32'h0,    0, 0};
        tbl[2]  = '{32'h100, 1, 32'h100, 1, 0, 1, 32'h0,    0, 1, 0, 32'h0,    1, 1};
        tbl[3]  = '{32'h100, 1, 32'h100, 1, 0, 1, 32'h0,    0, 1, 0, 32'h0,    2, 1};
        tbl[4]  = '{32'h100, 0, 32'h000, 0, 0, 0, 32'h0,    0, 1, 0, 32'h0,    3, 1};
        tbl[5]  = '{32'h100, 1, 32'h100, 1, 0, 0, 32'h0,    0, 1, 0, 32'h0,    3, 1};
        tbl[6]  = '{32'h100, 0, 32'h000, 0, 0, 0, 32'h0,    0, 1, 0, 32'h0,    4, 1};
        tbl[7]  = '{32'h104, 0, 32'h000, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    4, 1};
        tbl[8]  = '{32'h040, 1, 32'h040, 0, 1, 0, 32'h1235, 0, 0, 0, 32'h0,    4, 1};
        tbl[9]  = '{32'h040, 0, 32'h000, 0, 0, 0, 32'h0,    0, 0, 1, 32'h1234, 5, 1};
        tbl[10] = '{32'h060, 0, 32'h000, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,    5, 1};
        tbl[11] = '{32'h100, 0, 32'h100, 1, 0, 0, 32'h0,    1, 1, 0, 32'h0,    5, 1};
        tbl[12] = '{32'h100, 1, 32'h000, 0, 0, 0, 32'h0,    1, 1, 0, 32'h0,    5, 1};
        tbl[13] = '{32'h100, 0, 32'h000, 0, 0, 0, 32'h0,    0, 1, 0, 32'h0,    5, 2};

        lk_bneg = 1'b0;
        reset   = 1'b1;
        drive(32'h100, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        chk("reset pred_taken", 32'(b_pt), 32'd0);
        chk("reset jalr_hit", 32'(b_hit), 32'd0);
        chk("reset stat_branches", b_br, 32'd0);
        chk("reset stat_mispredicts", b_mis, 32'd0);
        step();
        reset = 1'b0;

        // Bimodal table: training, saturation, same-cycle lookup, BTB, hold
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].lk, tbl[i].uv, tbl[i].upc, tbl[i].ub, tbl[i].uj, tbl[i].ut,
                  tbl[i].utgt, tbl[i].um);
            @(negedge clk);
            chk($sformatf("row%0d pred_taken", i), 32'(b_pt), 32'(tbl[i].e_pt));
            chk($sformatf("row%0d jalr_hit", i), 32'(b_hit), 32'(tbl[i].e_hit));
            chk($sformatf("row%0d jalr_target", i), b_tgt, tbl[i].e_tgt);
            chk($sformatf("row%0d stat_branches", i), b_br, tbl[i].e_br);
            chk($sformatf("row%0d stat_mispredicts", i), b_mis, tbl[i].e_mis);
            step();
        end

        // Gshare: taken then not-taken at 0x200 leaves GHR = 000010
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(32'h0, 1, 32'h200, 1, 0, 1, 0, 0);
        step();
        drive(32'h0, 1, 32'h200, 1, 0, 0, 0, 0);
        step();
        drive(32'h200, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("gshare 0x200 -> idx 2", 32'(g_pt), 32'd0);
        chk("bimodal 0x200 -> idx 0", 32'(b_pt), 32'd0);
        lk_pc = 32'h208;
        #1;
        chk("gshare 0x208 -> idx 0", 32'(g_pt), 32'd1);
        chk("bimodal 0x208 -> idx 2", 32'(b_pt), 32'd0);
        chk("gshare stat_branches", g_br, 32'd2);
        step();

        // Five mispredicted JALRs, then asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            drive(32'h40, 1, 32'h40, 0, 1, 0, 32'h1235, 1);
            step();
        end
        drive(32'h40, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre-reset stat_mispredicts", b_mis, 32'd5);
        chk("pre-reset jalr_hit", 32'(b_hit), 32'd1);
        reset = 1'b1;
        #1;
        chk("async reset stat_mispredicts", b_mis, 32'd0);
        chk("async reset stat_branches", b_br, 32'd0);
        chk("async reset jalr_hit", 32'(b_hit), 32'd0);
        chk("async reset jalr_target", b_tgt, 32'd0);
        chk("async reset gshare pred", 32'(g_pt), 32'd0);
        step();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
